// File: rtl/axis_image_pkg.sv
// rtl/axis_image_pkg.sv - shared widths, FSM states and error-bit indices for the image receiver
package axis_image_pkg;

  localparam int DEF_TDATA_WIDTH = 32;
  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_DIM_WIDTH   = 16;
  localparam int STATS_WIDTH     = 16;

  typedef enum logic {
    SYNC = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam int ERR_EOL_EARLY = 0;
  localparam int ERR_EOL_LATE  = 1;
  localparam int ERR_SOF       = 2;
  localparam int ERR_WIDTH     = 3;

endpackage

// File: rtl/axis_rx_out_reg.sv
// rtl/axis_rx_out_reg.sv - valid/ready output register holding pixel data and coordinates
module axis_rx_out_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DIM_WIDTH-1:0]  in_row,
  input  logic [DIM_WIDTH-1:0]  in_col,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DIM_WIDTH-1:0]  row,
  output logic [DIM_WIDTH-1:0]  col
);

  // The parent only asserts load when the slot is empty or being drained this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      row   <= '0;
      col   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      row   <= in_row;
      col   <= in_col;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_image_receiver.sv
// rtl/axis_image_receiver.sv - AXI-Stream frame receiver emitting pixels with row/col coordinates
// Optional frame/error counters are built when AXIS_RX_STATS_EN is defined.
module axis_image_receiver
  import axis_image_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int PIXEL_WIDTH          = DEF_PIXEL_WIDTH,
  parameter int DIM_WIDTH            = DEF_DIM_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DIM_WIDTH-1:0]            cfg_cols,
  input  logic [DIM_WIDTH-1:0]            cfg_rows,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tuser,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                            s_axis_tready,
  output logic                            m_pix_valid,
  input  logic                            m_pix_ready,
  output logic [PIXEL_WIDTH-1:0]          m_pix_data,
  output logic [DIM_WIDTH-1:0]            m_pix_row,
  output logic [DIM_WIDTH-1:0]            m_pix_col,
  output logic                            frame_done,
  output logic [ERR_WIDTH-1:0]            err_flags
`ifdef AXIS_RX_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]          frame_count,
  output logic [STATS_WIDTH-1:0]          err_count
`endif
);

  localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state, state_n;
  logic [DIM_WIDTH-1:0]   cols_q, rows_q, col_q, row_q;
  logic [DIM_WIDTH-1:0]   cols_n, rows_n, col_n, row_n;
  logic [DIM_WIDTH-1:0]   pix_row, pix_col;
  logic                   can_load, beat, load, cfg_ok, at_eol, at_last_row, done_n;
  logic [ERR_WIDTH-1:0]   err_n;
  logic                   unused_tdata;

  assign unused_tdata  = ^s_axis_tdata;
  assign can_load      = !m_pix_valid || m_pix_ready;
  assign s_axis_tready = (state == SYNC) ? 1'b1 : can_load;
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign cfg_ok        = (cfg_cols != '0) && (cfg_rows != '0);
  assign at_eol        = (col_q == cols_q - DIM_ONE);
  assign at_last_row   = (row_q == rows_q - DIM_ONE);

  always_comb begin
    state_n = state;
    cols_n  = cols_q;
    rows_n  = rows_q;
    col_n   = col_q;
    row_n   = row_q;
    pix_row = row_q;
    pix_col = col_q;
    load    = 1'b0;
    done_n  = 1'b0;
    err_n   = '0;
    if (beat) begin
      if (s_axis_tuser) begin
        // A start-of-frame beat restarts the frame; tlast on it is ignored.
        if (state == RECV) err_n[ERR_SOF] = 1'b1;
        col_n   = '0;
        row_n   = '0;
        state_n = SYNC;
        // In SYNC ready stays high, so an SOF arriving while the previous
        // frame's last pixel is still held is dropped rather than overwriting it.
        if (cfg_ok && can_load) begin
          load    = 1'b1;
          pix_row = '0;
          pix_col = '0;
          cols_n  = cfg_cols;
          rows_n  = cfg_rows;
          state_n = RECV;
          if (cfg_cols == DIM_ONE) begin
            if (cfg_rows == DIM_ONE) begin
              done_n  = 1'b1;
              state_n = SYNC;
            end else begin
              row_n = DIM_ONE;
            end
          end else begin
            col_n = DIM_ONE;
          end
        end
      end else if (state == RECV) begin
        if (s_axis_tlast != at_eol) begin
          if (s_axis_tlast) err_n[ERR_EOL_EARLY] = 1'b1;
          else              err_n[ERR_EOL_LATE]  = 1'b1;
          col_n   = '0;
          row_n   = '0;
          state_n = SYNC;
        end else begin
          load = 1'b1;
          if (at_eol) begin
            col_n = '0;
            if (at_last_row) begin
              row_n   = '0;
              done_n  = 1'b1;
              state_n = SYNC;
            end else begin
              row_n = row_q + DIM_ONE;
            end
          end else begin
            col_n = col_q + DIM_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      cols_q     <= '0;
      rows_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      frame_done <= 1'b0;
      err_flags  <= '0;
    end else begin
      state      <= state_n;
      cols_q     <= cols_n;
      rows_q     <= rows_n;
      col_q      <= col_n;
      row_q      <= row_n;
      frame_done <= done_n;
      err_flags  <= err_n;
    end
  end

  axis_rx_out_reg #(
    .DATA_WIDTH(PIXEL_WIDTH),
    .DIM_WIDTH (DIM_WIDTH)
  ) u_out_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .in_data(s_axis_tdata[PIXEL_WIDTH-1:0]),
    .in_row (pix_row),
    .in_col (pix_col),
    .ready  (m_pix_ready),
    .valid  (m_pix_valid),
    .data   (m_pix_data),
    .row    (m_pix_row),
    .col    (m_pix_col)
  );

`ifdef AXIS_RX_STATS_EN
  localparam logic [STATS_WIDTH-1:0] STATS_ONE = {{(STATS_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (frame_done && (frame_count != '1)) frame_count <= frame_count + STATS_ONE;
      if ((|err_flags) && (err_count != '1)) err_count <= err_count + STATS_ONE;
    end
  end
`endif

endmodule

// File: doc/axis_image_receiver.md
AXIS_IMAGE_RECEIVER -- requirements
Module: axis_image_receiver

Interface
REQ-001 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32, AXI-Stream data width.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8, pixel width taken from tdata LSBs.
REQ-003 SHALL have parameter DIM_WIDTH, default 16, width of cfg and row/col buses.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk input 1 bit, rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port cfg_cols, input, DIM_WIDTH, beats per line (cols*channels).
REQ-007 SHALL have port cfg_rows, input, DIM_WIDTH, lines per frame.
REQ-008 SHALL have ports s_axis_tvalid/tlast/tuser, input, 1 bit each, slave stream controls.
REQ-009 SHALL have port s_axis_tdata, input, C_S_AXIS_TDATA_WIDTH, stream data.
REQ-010 SHALL have port s_axis_tready, output, 1 bit, slave ready.
REQ-011 SHALL have ports m_pix_valid output 1 bit, m_pix_ready input 1 bit, pixel handshake.
REQ-012 SHALL have ports m_pix_data output PIXEL_WIDTH, m_pix_row/m_pix_col output DIM_WIDTH, pixel and coordinates.
REQ-013 SHALL have ports frame_done, output, 1 bit, one-cycle end-of-frame pulse; err_flags, output, 3 bits, {err_sof, err_eol_late, err_eol_early} one-cycle pulses.

Function
REQ-014 SHALL implement FSM states SYNC and RECV; a beat is accepted when s_axis_tvalid && s_axis_tready.
REQ-015 SHALL drive s_axis_tready = 1 in SYNC, and !m_pix_valid || m_pix_ready in RECV.
REQ-016 SHALL, in SYNC, discard beats with tuser=0; on tuser=1 latch cfg_cols/cfg_rows, emit the beat as pixel (0,0), and enter RECV.
REQ-017 SHALL, if latched cfg_cols or cfg_rows is 0, discard the SOF beat and remain in SYNC.
REQ-018 SHALL register accepted pixels: m_pix_valid/data/row/col valid the cycle after acceptance, held until m_pix_ready; throughput one beat per cycle.
REQ-019 SHALL set m_pix_data = s_axis_tdata[PIXEL_WIDTH-1:0]; upper bits are ignored.
REQ-020 SHALL increment col per accepted beat; at col = cols-1 with tlast=1, reset col to 0 and increment row.
REQ-021 SHALL, on tlast=1 with col < cols-1, drop the beat, pulse err_eol_early, and enter SYNC.
REQ-022 SHALL, at col = cols-1 with tlast=0, drop the beat, pulse err_eol_late, and enter SYNC.
REQ-023 SHALL, on tuser=1 in RECV, pulse err_sof, re-latch cfg, emit the beat as (0,0), and stay in RECV.
REQ-024 SHALL, on the beat at row = rows-1, col = cols-1 with tlast=1, emit the pixel, pulse frame_done in the acceptance cycle+1, and enter SYNC.
REQ-025 SHALL give err_sof priority over the tlast checks when both apply to one beat.

Reset
REQ-026 SHALL, on reset assertion (including mid-frame), immediately force state=SYNC, counters=0, and m_pix_valid/data/row/col, frame_done and err_flags to 0; s_axis_tready follows REQ-015 (1).

Configuration
REQ-027 SHALL, with AXIS_RX_STATS_EN defined, add outputs frame_count and err_count (16 bits each, saturating, reset 0), counting frame_done pulses and any err_flags pulse.
REQ-028 SHALL, without AXIS_RX_STATS_EN, omit those ports and counters entirely.

Structure
REQ-029 SHALL place the state enum (SYNC, RECV), err_flags bit indices and the default widths in package axis_image_pkg.
REQ-030 SHALL implement the output register stage as sub-module axis_rx_out_reg (valid/ready register holding data, row and col).

Verification
REQ-031 cfg 4x3 (cols=4, rows=3), 12 beats of data 1..12, tuser on beat 0, tlast on beats 3, 7, 11, m_pix_ready=1 -> 12 pixels with (row,col) (0,0)..(2,3), data 1..12, one frame_done, err_flags=0.
REQ-032 Same frame with m_pix_ready toggled 1,0 every cycle -> no pixel lost or duplicated; s_axis_tready low whenever m_pix_valid && !m_pix_ready.
REQ-033 tlast on beat 2 of line 0 -> err_eol_early pulse, beat dropped, next beats discarded until tuser; following good frame received intact.
REQ-034 tuser on beat 5 mid-frame -> err_sof pulse, beat emitted as (0,0); frame_done only after 12 further correct beats.
REQ-035 reset asserted after beat 6 -> m_pix_valid=0 immediately; after release a full 4x3 frame completes normally.
REQ-036 With AXIS_RX_STATS_EN: two good frames plus one eol error -> frame_count=2, err_count=1.
